// File: rtl/hack_cpu_ws_pkg.sv
// Shared definitions for the wait-state Hack CPU: FSM states, IR field positions,
// ALU control decode and jump condition helpers.
package hack_cpu_ws_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_READ  = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

  localparam int IR_CI  = 15;
  localparam int IR_A   = 12;
  localparam int IR_ZX  = 11;
  localparam int IR_NO  = 6;
  localparam int IR_DA  = 5;
  localparam int IR_DD  = 4;
  localparam int IR_DM  = 3;
  localparam int IR_JLT = 2;
  localparam int IR_JGT = 0;

  typedef struct packed {
    logic zx;
    logic nx;
    logic zy;
    logic ny;
    logic f;
    logic no;
  } alu_ctl_t;

  function automatic alu_ctl_t decode_alu(input logic [5:0] comp);
    alu_ctl_t c;
    c = alu_ctl_t'(comp);
    return c;
  endfunction

  // jmp = {jlt, jeq, jgt}
  function automatic logic jump_taken(input logic [2:0] jmp, input logic zr, input logic ng);
    return (jmp[2] & ng) | (jmp[1] & zr) | (jmp[0] & ~ng & ~zr);
  endfunction

endpackage

// File: rtl/hack_cpu_ws_alu.sv
// Combinational Hack ALU (zx/nx/zy/ny/f/no) at DATA_W bits with zero and negative flags.
module hack_cpu_ws_alu
  import hack_cpu_ws_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] y,
  input  alu_ctl_t          ctl,
  output logic [DATA_W-1:0] out,
  output logic              zr,
  output logic              ng
);

  logic [DATA_W-1:0] x_m;
  logic [DATA_W-1:0] y_m;
  logic [DATA_W-1:0] f_out;

  always_comb begin
    x_m = ctl.zx ? '0 : x;
    if (ctl.nx) x_m = ~x_m;
    y_m = ctl.zy ? '0 : y;
    if (ctl.ny) y_m = ~y_m;
    f_out = ctl.f ? (x_m + y_m) : (x_m & y_m);
    out   = ctl.no ? ~f_out : f_out;
    zr    = (out == '0);
    ng    = out[DATA_W-1];
  end

endmodule

// File: rtl/hack_cpu_ws.sv
// Multicycle Hack CPU with valid/ready fetch, read and write handshakes.
// Optional HACK_CPU_PERF_CNT_EN adds cycle and retired-instruction counters.
module hack_cpu_ws
  import hack_cpu_ws_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 15,
  parameter int PC_W   = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       instruction,
  input  logic              instr_valid,
  output logic              instr_req,
  output logic [PC_W-1:0]   pcaddr,
  input  logic [DATA_W-1:0] inM,
  input  logic              inM_valid,
  output logic              read_req,
  output logic [DATA_W-1:0] outM,
  output logic              writeM,
  input  logic              wready,
  output logic [ADDR_W-1:0] addressM
`ifdef HACK_CPU_PERF_CNT_EN
  ,
  output logic [31:0]       cyc_cnt,
  output logic [31:0]       instret_cnt
`endif
);

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PC_W-1:0]   pc_pend_q, pc_pend_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] dreg_q, dreg_d;
  logic [15:0]       ir_q, ir_d;
  logic [DATA_W-1:0] mreg_q, mreg_d;
  logic              mhave_q, mhave_d;
  logic [ADDR_W-1:0] addr_r_q, addr_r_d;
  logic [DATA_W-1:0] outm_q, outm_d;

  logic [DATA_W-1:0] alu_out;
  logic              alu_zr;
  logic              alu_ng;
  logic [PC_W-1:0]   pc_next;

  hack_cpu_ws_alu #(.DATA_W(DATA_W)) u_alu (
    .x   (dreg_q),
    .y   (ir_q[IR_A] ? mreg_q : a_q),
    .ctl (decode_alu(ir_q[IR_ZX:IR_NO])),
    .out (alu_out),
    .zr  (alu_zr),
    .ng  (alu_ng)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH: if (instr_valid) state_d = ST_EXEC;
      ST_EXEC: begin
        if (!ir_q[IR_CI])                  state_d = ST_FETCH;
        else if (ir_q[IR_A] && !mhave_q)   state_d = ST_READ;
        else if (ir_q[IR_DM])              state_d = ST_WRITE;
        else                               state_d = ST_FETCH;
      end
      ST_READ:  if (inM_valid) state_d = ST_EXEC;
      ST_WRITE: if (wready)    state_d = ST_FETCH;
      default:  state_d = ST_FETCH;
    endcase
  end

  always_comb begin
    instr_req = (state_q == ST_FETCH);
    read_req  = (state_q == ST_READ);
    writeM    = (state_q == ST_WRITE);
    addressM  = (state_q == ST_WRITE) ? addr_r_q : a_q[ADDR_W-1:0];
    pcaddr    = pc_q;
    outM      = outm_q;
  end

  // Jump target and write address both use A as it was before this instruction.
  always_comb begin
    pc_d      = pc_q;
    pc_pend_d = pc_pend_q;
    a_d       = a_q;
    dreg_d    = dreg_q;
    ir_d      = ir_q;
    mreg_d    = mreg_q;
    mhave_d   = mhave_q;
    addr_r_d  = addr_r_q;
    outm_d    = outm_q;
    pc_next   = jump_taken(ir_q[IR_JLT:IR_JGT], alu_zr, alu_ng) ? a_q[PC_W-1:0]
                                                                : pc_q + PC_W'(1);
    case (state_q)
      ST_FETCH: begin
        if (instr_valid) begin
          ir_d    = instruction;
          mhave_d = 1'b0;
        end
      end
      ST_EXEC: begin
        if (!ir_q[IR_CI]) begin
          a_d  = {{(DATA_W-15){1'b0}}, ir_q[14:0]};
          pc_d = pc_q + PC_W'(1);
        end else if (!(ir_q[IR_A] && !mhave_q)) begin
          addr_r_d = a_q[ADDR_W-1:0];
          outm_d   = alu_out;
          if (ir_q[IR_DA]) a_d = alu_out;
          if (ir_q[IR_DD]) dreg_d = alu_out;
          // With a pending write the next fetch waits, so PC is held until wready.
          if (ir_q[IR_DM]) pc_pend_d = pc_next;
          else             pc_d = pc_next;
        end
      end
      ST_READ: begin
        if (inM_valid) begin
          mreg_d  = inM;
          mhave_d = 1'b1;
        end
      end
      ST_WRITE: if (wready) pc_d = pc_pend_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q      <= '0;
      pc_pend_q <= '0;
      a_q       <= '0;
      dreg_q    <= '0;
      ir_q      <= '0;
      mreg_q    <= '0;
      mhave_q   <= 1'b0;
      addr_r_q  <= '0;
      outm_q    <= '0;
    end else begin
      pc_q      <= pc_d;
      pc_pend_q <= pc_pend_d;
      a_q       <= a_d;
      dreg_q    <= dreg_d;
      ir_q      <= ir_d;
      mreg_q    <= mreg_d;
      mhave_q   <= mhave_d;
      addr_r_q  <= addr_r_d;
      outm_q    <= outm_d;
    end
  end

`ifdef HACK_CPU_PERF_CNT_EN
  logic [31:0] cyc_q, cyc_d;
  logic [31:0] instret_q, instret_d;

  always_comb begin
    cyc_d     = cyc_q + 32'd1;
    instret_d = instret_q;
    if ((state_q == ST_EXEC || state_q == ST_WRITE) && state_d == ST_FETCH)
      instret_d = instret_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_q     <= '0;
      instret_q <= '0;
    end else begin
      cyc_q     <= cyc_d;
      instret_q <= instret_d;
    end
  end

  assign cyc_cnt     = cyc_q;
  assign instret_cnt = instret_q;
`endif

endmodule
